// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package rf_pkg;

    localparam int RF_WIDTH   = 16;
    localparam int RF_REGBITS = 4;

    // Register 0 is hardwired to zero; writes to it are consumed without a strobe.
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic {
        WB_SRC_A = 1'b0,
        WB_SRC_M = 1'b1
    } wb_src_t;

    function automatic wb_src_t other_src(input wb_src_t s);
        return (s == WB_SRC_A) ? WB_SRC_M : WB_SRC_A;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a one-bit pointer names the favoured source.
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_m,
    output logic gnt_a,
    output logic gnt_m
);

    wb_src_t favour_q, favour_d;

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        favour_d = favour_q;
        gnt_a    = req_a && (!req_m || favour_q == WB_SRC_A);
        gnt_m    = req_m && (!req_a || favour_q == WB_SRC_M);
        // Whoever wins hands priority to the other source; idle cycles keep it.
        if (gnt_a) begin
            favour_d = other_src(WB_SRC_A);
        end else if (gnt_m) begin
            favour_d = other_src(WB_SRC_M);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            favour_q <= WB_SRC_M;
        end else begin
            favour_q <= favour_d;
        end
    end

    a_onehot : assert property (@(posedge clk) disable iff (reset) !(gnt_a && gnt_m));
    a_gnt_req : assert property (@(posedge clk) disable iff (reset)
                                 (!gnt_a || req_a) && (!gnt_m || req_m));

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter (ALU vs load return) with registered write stage.
// Optional outstanding-load scoreboard is built when RF_SCOREBOARD_EN is defined.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int WIDTH   = RF_WIDTH,
    parameter int REGBITS = RF_REGBITS
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               a_valid,
    output logic               a_ready,
    input  logic [REGBITS-1:0] a_addr,
    input  logic [WIDTH-1:0]   a_data,

    input  logic               m_valid,
    output logic               m_ready,
    input  logic [REGBITS-1:0] m_addr,
    input  logic [WIDTH-1:0]   m_data,

    output logic               regWrite,
    output logic [REGBITS-1:0] destAddr,
    output logic [WIDTH-1:0]   wrData,

    input  logic               sb_set,
    input  logic [REGBITS-1:0] sb_set_addr,
    input  logic [REGBITS-1:0] chk_addr1,
    input  logic [REGBITS-1:0] chk_addr2,
    output logic               chk_busy1,
    output logic               chk_busy2,
    output logic               sb_err
);

    localparam logic [REGBITS-1:0] ZERO_ADDR = REGBITS'(REG_ZERO);

    logic               reg_write_q, reg_write_d;
    logic [REGBITS-1:0] dest_addr_q, dest_addr_d;
    logic [WIDTH-1:0]   wr_data_q,   wr_data_d;
    wb_src_t            src_q,       src_d;

    logic               accept;
    logic [REGBITS-1:0] sel_addr;
    logic [WIDTH-1:0]   sel_data;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_a (a_valid),
        .req_m (m_valid),
        .gnt_a (a_ready),
        .gnt_m (m_ready)
    );

    always_comb begin
        accept      = a_ready || m_ready;
        sel_addr    = m_ready ? m_addr : a_addr;
        sel_data    = m_ready ? m_data : a_data;
        reg_write_d = 1'b0;
        dest_addr_d = dest_addr_q;
        wr_data_d   = wr_data_q;
        src_d       = src_q;
        if (accept) begin
            // A beat to register 0 is consumed but never strobed into the file.
            reg_write_d = (sel_addr != ZERO_ADDR);
            dest_addr_d = sel_addr;
            wr_data_d   = sel_data;
            src_d       = m_ready ? WB_SRC_M : WB_SRC_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            dest_addr_q <= '0;
            wr_data_q   <= '0;
            src_q       <= WB_SRC_A;
        end else begin
            reg_write_q <= reg_write_d;
            dest_addr_q <= dest_addr_d;
            wr_data_q   <= wr_data_d;
            src_q       <= src_d;
        end
    end

    assign regWrite = reg_write_q;
    assign destAddr = dest_addr_q;
    assign wrData   = wr_data_q;

`ifdef RF_SCOREBOARD_EN

    localparam int NREGS = 1 << REGBITS;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             sb_err_q, sb_err_d;
    logic             m_commit;

    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        // The committing write is the one currently on the register-file port.
        m_commit = reg_write_q && (src_q == WB_SRC_M);
        if (m_commit) begin
            if (!busy_q[dest_addr_q]) begin
                sb_err_d = 1'b1;
            end
            busy_d[dest_addr_q] = 1'b0;
        end
        // A new load issue to the same register overrides the clear.
        if (sb_set && sb_set_addr != ZERO_ADDR) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // NOTE: the busy vector is small flop storage that must start clean, so it is reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign chk_busy1 = busy_q[chk_addr1];
    assign chk_busy2 = busy_q[chk_addr2];
    assign sb_err    = sb_err_q;

`else

    logic unused_sb;
    assign unused_sb = ^{sb_set, sb_set_addr, chk_addr1, chk_addr2, src_q};

    assign chk_busy1 = 1'b0;
    assign chk_busy2 = 1'b0;
    assign sb_err    = 1'b0;

`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter; scoreboard checks follow RF_SCOREBOARD_EN.
module tb_rf_write_arbiter;

    localparam int W  = 16;
    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid, a_ready, m_valid, m_ready;
    logic [RB-1:0] a_addr, m_addr, destAddr, sb_set_addr, chk_addr1, chk_addr2;
    logic [W-1:0]  a_data, m_data, wrData;
    logic          regWrite, sb_set, chk_busy1, chk_busy2, sb_err;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.WIDTH(W), .REGBITS(RB)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_addr      (m_addr),
        .m_data      (m_data),
        .regWrite    (regWrite),
        .destAddr    (destAddr),
        .wrData      (wrData),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .chk_addr1   (chk_addr1),
        .chk_addr2   (chk_addr2),
        .chk_busy1   (chk_busy1),
        .chk_busy2   (chk_busy2),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_valid = 1'b0;
        m_valid = 1'b0;
        sb_set  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Contention stimulus: grant order after reset is M, A, M, A.
    logic [W-1:0] a_vals [2] = '{16'hA000, 16'hA001};
    logic [W-1:0] m_vals [2] = '{16'hC000, 16'hC001};
    logic [3:0]   exp_m_gnt = 4'b0101;

    initial begin
        int ai;
        int mi;
        idle();
        a_addr = '0; a_data = '0; m_addr = '0; m_data = '0;
        sb_set_addr = '0; chk_addr1 = '0; chk_addr2 = '0;

        // Reset state
        #12;
        check("rst_regWrite", regWrite, 0);
        check("rst_destAddr", destAddr, 0);
        check("rst_wrData", wrData, 0);
        check("rst_sb_err", sb_err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Contention: both valid for four cycles
        ai = 0; mi = 0;
        a_valid = 1'b1; a_addr = 4'd1;
        m_valid = 1'b1; m_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            a_data = a_vals[ai];
            m_data = m_vals[mi];
            #1;
            check("cont_m_ready", m_ready, exp_m_gnt[i]);
            check("cont_a_ready", a_ready, !exp_m_gnt[i]);
            @(negedge clk);
            check("cont_regWrite", regWrite, 1);
            check("cont_destAddr", destAddr, exp_m_gnt[i] ? 2 : 1);
            check("cont_wrData", wrData, exp_m_gnt[i] ? m_vals[mi] : a_vals[ai]);
            if (exp_m_gnt[i]) mi++; else ai++;
        end
        idle();
        @(negedge clk);
        check("idle_regWrite", regWrite, 0);
        check("idle_destAddr_hold", destAddr, 1);
        check("idle_wrData_hold", wrData, 16'hA001);

        // Single ALU source
        a_valid = 1'b1; a_addr = 4'd3; a_data = 16'h1234;
        #1;
        check("single_a_ready", a_ready, 1);
        check("single_m_ready", m_ready, 0);
        @(negedge clk);
        idle();
        check("single_regWrite", regWrite, 1);
        check("single_destAddr", destAddr, 3);
        check("single_wrData", wrData, 16'h1234);

        // Lone M grant hands priority to A
        m_valid = 1'b1; m_addr = 4'd7; m_data = 16'h7777;
        #1;
        check("lone_m_ready", m_ready, 1);
        @(negedge clk);
        check("lone_destAddr", destAddr, 7);
        a_valid = 1'b1; a_addr = 4'd4; a_data = 16'h4444;
        m_valid = 1'b1; m_addr = 4'd8; m_data = 16'h8888;
        #1;
        check("after_lone_a_ready", a_ready, 1);
        check("after_lone_m_ready", m_ready, 0);
        @(negedge clk);
        a_valid = 1'b0;
        check("after_lone_wrData", wrData, 16'h4444);
        #1;
        check("next_m_ready", m_ready, 1);
        @(negedge clk);
        idle();
        check("next_destAddr", destAddr, 8);
        check("next_wrData", wrData, 16'h8888);

        // Register 0: consumed, no strobe
        a_valid = 1'b1; a_addr = 4'd0; a_data = 16'hFFFF;
        #1;
        check("r0_a_ready", a_ready, 1);
        @(negedge clk);
        idle();
        check("r0_regWrite", regWrite, 0);
        check("r0_wrData", wrData, 16'hFFFF);

        // Reset mid-write: pointer favours A beforehand, M afterwards
        sb_set = 1'b1; sb_set_addr = 4'd5; chk_addr1 = 4'd5;
        m_valid = 1'b1; m_addr = 4'd9; m_data = 16'hBEEF;
        #1;
        check("prerst_m_ready", m_ready, 1);
        @(negedge clk);
        idle();
        check("prerst_regWrite", regWrite, 1);
`ifdef RF_SCOREBOARD_EN
        check("prerst_busy5", chk_busy1, 1);
`endif
        reset = 1'b1;
        #1;
        check("midrst_regWrite", regWrite, 0);
        check("midrst_destAddr", destAddr, 0);
        check("midrst_wrData", wrData, 0);
        check("midrst_busy5", chk_busy1, 0);
        @(negedge clk);
        reset = 1'b0;
        a_valid = 1'b1; a_addr = 4'd1;
        m_valid = 1'b1; m_addr = 4'd2;
        #1;
        check("postrst_m_ready", m_ready, 1);
        check("postrst_a_ready", a_ready, 0);
        do_reset();

`ifdef RF_SCOREBOARD_EN
        // Busy visible through N+1, cleared at N+2
        chk_addr1 = 4'd5; chk_addr2 = 4'd0;
        sb_set = 1'b1; sb_set_addr = 4'd5;
        @(negedge clk);
        sb_set = 1'b0;
        check("sb_busy_set", chk_busy1, 1);
        check("sb_r0_busy", chk_busy2, 0);
        m_valid = 1'b1; m_addr = 4'd5; m_data = 16'h0505;
        #1;
        check("sb_busy_N", chk_busy1, 1);
        @(negedge clk);
        idle();
        check("sb_regWrite_N1", regWrite, 1);
        check("sb_busy_N1", chk_busy1, 1);
        @(negedge clk);
        check("sb_busy_N2", chk_busy1, 0);
        check("sb_err_clean", sb_err, 0);

        // Set and clear on the same edge: set wins
        sb_set = 1'b1; sb_set_addr = 4'd5;
        @(negedge clk);
        sb_set = 1'b0;
        m_valid = 1'b1; m_addr = 4'd5; m_data = 16'h0555;
        @(negedge clk);
        m_valid = 1'b0;
        sb_set = 1'b1; sb_set_addr = 4'd5;
        @(negedge clk);
        sb_set = 1'b0;
        check("sb_setwins_busy", chk_busy1, 1);
        check("sb_setwins_err", sb_err, 0);

        // M write to a non-busy register flags an error that sticks
        m_valid = 1'b1; m_addr = 4'd6; m_data = 16'h0666;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("sb_err_set", sb_err, 1);
        @(negedge clk);
        @(negedge clk);
        check("sb_err_sticky", sb_err, 1);
        check("sb_busy5_kept", chk_busy1, 1);
`else
        // Scoreboard compiled out: status outputs stay low
        chk_addr1 = 4'd5; chk_addr2 = 4'd5;
        sb_set = 1'b1; sb_set_addr = 4'd5;
        @(negedge clk);
        sb_set = 1'b0;
        check("nosb_busy1", chk_busy1, 0);
        check("nosb_busy2", chk_busy2, 0);
        m_valid = 1'b1; m_addr = 4'd6; m_data = 16'h0666;
        @(negedge clk);
        idle();
        check("nosb_regWrite", regWrite, 1);
        @(negedge clk);
        check("nosb_err", sb_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
